// File: rtl/turf_dna_reader.sv
// rtl/turf_dna_reader.sv - DNA_PORTE2 read sequencer with a Wishbone register window
//
// Purpose: pulses READ on the device DNA port, shifts out the 96 DNA bits and
// latches them into dna_o. This happens once after reset when AUTO_START is set,
// and again whenever software writes CTRL with bit31 set while the block is idle.
// The DNA is presented as three read-only 32-bit words next to a control/status word.
//
// Ports:
//   wb_clk_i, wb_rst_ni         clock (also clocks the DNA primitive), async active-low reset
//   wb_cyc_i, wb_stb_i, wb_we_i Wishbone cycle / strobe / write enable
//   wb_adr_i[3:2]               register select: 0 CTRL/STAT, 1..3 dna_o words
//   wb_dat_i, wb_dat_o          write data / registered read data
//   wb_ack_o                    single-cycle acknowledge; wb_err_o, wb_rty_o tied 0
//   dna_read_o, dna_shift_o     READ / SHIFT to DNA_PORTE2
//   dna_dout_i                  DOUT from DNA_PORTE2
//   dna_o, dna_valid_o          latched DNA (bit 0 = first bit out), completed-read flag

module turf_dna_reader #(
  parameter int unsigned CLK_DIV    = 1,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic        dna_read_o,
  output logic        dna_shift_o,
  input  logic        dna_dout_i,
  output logic [95:0] dna_o,
  output logic        dna_valid_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_presc;
  logic [6:0]  r_bit_cnt;
  logic [95:0] r_sr;
  logic [95:0] r_dna;
  logic        r_valid;
  logic [7:0]  r_seq_cnt;
  logic        r_auto_pend;
  logic        r_ack;
  logic [31:0] r_dat;

  logic        w_tick;
  logic        w_busy;
  logic        w_last_bit;
  logic        w_access;
  logic        w_sw_start;
  logic        w_start;
  logic [31:0] w_rd_mux;
  logic        w_unused;

  assign w_tick     = (r_presc == DIV_LAST);
  assign w_busy     = (r_state != S_IDLE);
  assign w_last_bit = (r_bit_cnt == 7'd95);
  // One access per strobe: the cycle that raises the ack is the cycle the access acts.
  assign w_access   = wb_cyc_i && wb_stb_i && !r_ack;
  assign w_sw_start = w_access && wb_we_i && (wb_adr_i[3:2] == 2'd0) && wb_dat_i[31];
  // Start requests are only honoured in IDLE (see next-state logic), so a request
  // while busy or during DONE is simply dropped rather than queued.
  assign w_start    = r_auto_pend || w_sw_start;
  assign w_unused   = ^{wb_adr_i[1:0], wb_dat_i[30:0]};

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_state_nxt = S_LOAD;
      S_LOAD:    if (w_tick) w_state_nxt = S_CAPTURE;
      S_CAPTURE: if (w_tick && w_last_bit) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: the last capture tick reads DOUT without shifting, so 95 shifts
  // present all 96 bits.
  always_comb begin
    dna_read_o  = 1'b0;
    dna_shift_o = 1'b0;
    case (r_state)
      S_LOAD:    dna_read_o  = w_tick;
      S_CAPTURE: dna_shift_o = w_tick && !w_last_bit;
      default: begin
        dna_read_o  = 1'b0;
        dna_shift_o = 1'b0;
      end
    endcase
  end

  // Prescaler, bit counter and capture datapath. The prescaler idles at 0, so it
  // is already clear on entry to LOAD.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_presc     <= 8'd0;
      r_bit_cnt   <= 7'd0;
      r_sr        <= '0;
      r_dna       <= '0;
      r_valid     <= 1'b0;
      r_seq_cnt   <= 8'd0;
      r_auto_pend <= AUTO_START;
    end else begin
      r_auto_pend <= 1'b0;
      case (r_state)
        S_LOAD: begin
          r_presc <= w_tick ? 8'd0 : r_presc + 8'd1;
          if (w_tick) r_bit_cnt <= 7'd0;
        end
        S_CAPTURE: begin
          r_presc <= w_tick ? 8'd0 : r_presc + 8'd1;
          if (w_tick) begin
            // The primitive shifts on this same edge, so the pre-shift DOUT is taken.
            r_sr      <= {dna_dout_i, r_sr[95:1]};
            r_bit_cnt <= r_bit_cnt + 7'd1;
          end
        end
        S_DONE: begin
          r_dna     <= r_sr;
          r_valid   <= 1'b1;
          r_seq_cnt <= r_seq_cnt + 8'd1;
        end
        default: begin
          r_presc   <= 8'd0;
          r_bit_cnt <= 7'd0;
        end
      endcase
    end
  end

  // Register read mux
  always_comb begin
    w_rd_mux = 32'd0;
    case (wb_adr_i[3:2])
      2'd0:    w_rd_mux = {16'd0, r_seq_cnt, 6'd0, w_busy, r_valid};
      2'd1:    w_rd_mux = r_dna[31:0];
      2'd2:    w_rd_mux = r_dna[63:32];
      default: w_rd_mux = r_dna[95:64];
    endcase
  end

  // Wishbone ack and registered read data
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack <= 1'b0;
      r_dat <= 32'd0;
    end else begin
      r_ack <= w_access;
      if (w_access) r_dat <= w_rd_mux;
    end
  end

  assign wb_ack_o    = r_ack && wb_cyc_i;
  assign wb_dat_o    = r_dat;
  assign wb_err_o    = 1'b0;
  assign wb_rty_o    = 1'b0;
  assign dna_o       = r_dna;
  assign dna_valid_o = r_valid;

endmodule

// File: doc/turf_dna_reader.md
Name: turf_dna_reader

Overview:
- Autonomous sequencer for the device DNA port (DNA_PORTE2, instantiated by the parent).
- Loads the 96-bit DNA, shifts it out serially and latches it into shadow registers.
- Presents the shadow registers on a small Wishbone target window in the TURF ID/control space, so software reads the full DNA in three accesses instead of bit-banging.
- Runs once automatically after reset; software can rerun it on demand.

Parameters:
- CLK_DIV, 1: wb_clk_i cycles per DNA port step (1..255). Keeps the primitive clock enable within its rated rate.
- AUTO_START, 1: 1 = start one read sequence when reset releases.

Ports:
- wb_clk_i  in  1  Wishbone/system clock; also clocks the DNA primitive.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  Wishbone write enable.
- wb_adr_i  in  4  byte address; bits [3:2] select the register.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  acknowledge.
- wb_err_o  out  1  tied 0.
- wb_rty_o  out  1  tied 0.
- dna_read_o  out  1  to DNA_PORTE2 READ.
- dna_shift_o  out  1  to DNA_PORTE2 SHIFT.
- dna_dout_i  in  1  from DNA_PORTE2 DOUT.
- dna_o  out  96  latched DNA, bit 0 = first bit out.
- dna_valid_o  out  1  dna_o holds a completed read.

Behaviour:
- Reset (async assert, sync release): state IDLE, all counters 0, dna_o = 0, dna_valid_o = 0, wb_ack_o = 0, dna_read_o = 0, dna_shift_o = 0.
- If AUTO_START = 1, a start request is pending on the first clock after reset release.
- Prescaler:
  - 8-bit counter runs only in LOAD and CAPTURE; cleared on entry to LOAD.
  - tick = (counter == CLK_DIV-1); counter wraps to 0 on tick.
  - With CLK_DIV = 1, tick is high every cycle.
- FSM states: IDLE, LOAD, CAPTURE, DONE.
  - IDLE -> LOAD on a start request (auto or software).
  - LOAD: dna_read_o = tick (combinational decode of the registered state). On tick go to CAPTURE with bit_cnt = 0.
  - CAPTURE, on each tick:
    - sr <= {dna_dout_i, sr[95:1]}.
    - dna_shift_o = tick && (bit_cnt != 95).
    - The primitive shifts on the same edge that samples, so the old DOUT is captured.
    - bit_cnt increments; on the tick with bit_cnt == 95, go to DONE.
  - DONE (one cycle): dna_o <= sr, dna_valid_o <= 1, go to IDLE.
- Latency: dna_valid_o rises exactly 97*CLK_DIV + 1 cycles after the cycle in which the FSM enters LOAD.
  - READ costs one tick and capture costs 96 ticks.
  - Exactly one dna_read_o pulse and exactly 95 dna_shift_o pulses per sequence, each one cycle wide.
- Rerun behaviour:
  - dna_o and dna_valid_o keep their previous values during a rerun; dna_o updates only in DONE.
  - dna_valid_o is never cleared except by reset.
- Register map (dword select = wb_adr_i[3:2]):
  - 0: CTRL/STAT. Read bit0 = dna_valid_o, bit1 = busy (state != IDLE), bits[15:8] = number of completed sequences (mod 256), other bits 0. Write with bit31 = 1 requests a start.
  - 1: dna_o[31:0], read-only.
  - 2: dna_o[63:32], read-only.
  - 3: dna_o[95:64], read-only.
  - Writes to registers 1–3 are acknowledged and ignored.
- Start-request rules:
  - A start request while busy is ignored; it is not queued.
  - A start request that coincides with DONE is ignored.
- Wishbone handshake:
  - wb_ack_o <= wb_cyc_i && wb_stb_i && !wb_ack_o, giving one ack per access, single cycle, 1-cycle latency.
  - Back-to-back strobes are acked every other cycle.
  - The output is qualified so that wb_ack_o is 0 whenever wb_cyc_i is 0.
  - wb_dat_o is registered alongside the ack.
  - A write takes effect in the cycle the ack is issued.
- Reset during LOAD/CAPTURE: abort immediately, no further pulses, and dna_o/dna_valid_o clear to 0.

Test Plan:
- Behavioural DNA model holding 96'hA5C3_0F1E_DEAD_BEEF_1234_5678; AUTO_START = 1, CLK_DIV = 1 -> dna_valid_o high exactly 98 cycles after LOAD entry; reads of dwords 1/2/3 return 0x12345678, 0xDEADBEEF, 0xA5C30F1E; CTRL reads 0x0000_0101.
- CLK_DIV = 4 -> valid after 389 cycles; every read/shift pulse is one cycle wide, spaced 4 cycles apart; pulse counts are 1 and 95.
- Write 0x8000_0000 to CTRL while busy -> ignored: count reaches only 1 and exactly 95 shifts occur; write again after done with the model value changed -> old dna_o is held until DONE, then the new value appears and the count becomes 2.
- Assert wb_rst_ni low mid-CAPTURE at bit 40 -> all outputs are 0 asynchronously; after release the sequence reruns from LOAD and completes correctly.
- Wishbone: strobe held for 6 cycles -> exactly 3 acks; wb_cyc_i dropped with the ack pending -> wb_ack_o is 0; writes to dwords 1–3 are acked and the data is unchanged.
